// File: rtl/neosd_card_cmd_if.sv
// User-side handshake bundle of neosd_card_cmd: decoded command out, response request in.
interface neosd_card_cmd_if;
   logic         cmd_valid_o;
   logic [5:0]   cmd_idx_o;
   logic [31:0]  cmd_arg_o;
   logic         cmd_crc_ok_o;
   logic         resp_valid_i;
   logic         resp_skip_i;
   logic         resp_long_i;
   logic [5:0]   resp_idx_i;
   logic [31:0]  resp_arg_i;
   logic [126:0] resp_data_i;
   logic         busy_o;

   modport master (
      output cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_crc_ok_o, busy_o,
      input  resp_valid_i, resp_skip_i, resp_long_i, resp_idx_i, resp_arg_i, resp_data_i
   );

   modport slave (
      input  cmd_valid_o, cmd_idx_o, cmd_arg_o, cmd_crc_ok_o, busy_o,
      output resp_valid_i, resp_skip_i, resp_long_i, resp_idx_i, resp_arg_i, resp_data_i
   );
endinterface

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD responder: oversamples sd_clk, decodes 48-bit commands, serialises responses.
// Define NEOSD_CARD_LONG_RESP_EN to enable the 136-bit R2 response path.
module neosd_card_cmd #(
   parameter int NCR         = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic sd_clk_i,
   input  logic sd_cmd_i,
   output logic sd_cmd_o,
   output logic sd_cmd_oe,
   neosd_card_cmd_if.master user
);

`ifdef NEOSD_CARD_LONG_RESP_EN
   localparam int SR_W = 136;
`else
   localparam int SR_W = 48;
`endif
   localparam logic [6:0] NCR_V = 7'(NCR);

   typedef enum logic [2:0] {IDLE, RX, WAIT_RESP, NCR_WAIT, TX, RELEASE} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] clk_sync, cmd_sync;
   logic                   clk_prev;
   logic                   sclk, scmd, rise, fall;
   logic [7:0]             bit_cnt;
   logic [6:0]             gap;
   logic [6:0]             crc;
   logic [44:0]            rx_sr;
   logic [SR_W-1:0]        tx_sr;
   logic [7:0]             tx_last;
   logic [47:0]            resp_short;
   logic                   resp_take, tx_go, tx_step, tx_end;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   function automatic logic [6:0] crc7_40(input logic [39:0] d);
      logic [6:0] c;
      c = '0;
      for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
      return c;
   endfunction

   assign sclk       = clk_sync[SYNC_STAGES-1];
   assign scmd       = cmd_sync[SYNC_STAGES-1];
   assign rise       = sclk & ~clk_prev;
   assign fall       = ~sclk & clk_prev;
   assign resp_short = {2'b00, user.resp_idx_i, user.resp_arg_i,
                        crc7_40({2'b00, user.resp_idx_i, user.resp_arg_i}), 1'b1};
   assign resp_take  = (state == WAIT_RESP) && !user.resp_skip_i && user.resp_valid_i;
   assign tx_go      = (state == NCR_WAIT) && fall && (gap == NCR_V);
   assign tx_step    = (state == TX) && fall;
   assign tx_end     = tx_step && (bit_cnt == tx_last);

`ifndef NEOSD_CARD_LONG_RESP_EN
   logic unused_long;
   assign unused_long = user.resp_long_i ^ (^user.resp_data_i);
`endif

   always_ff @(posedge clk_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (rise && !scmd) state_nxt = RX;
         RX: begin
            // bit_cnt==1 is the transmission bit: 0 means another card is talking
            if (rise && bit_cnt == 8'd1 && !scmd) state_nxt = IDLE;
            else if (rise && bit_cnt == 8'd47)    state_nxt = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (user.resp_skip_i)       state_nxt = IDLE;
            else if (user.resp_valid_i) state_nxt = NCR_WAIT;
         end
         NCR_WAIT:  if (tx_go)  state_nxt = TX;
         TX:        if (tx_end) state_nxt = RELEASE;
         RELEASE:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sd_cmd_oe   = (state == TX);
      user.busy_o = (state != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         clk_sync          <= '0;
         cmd_sync          <= '0;
         clk_prev          <= 1'b0;
         sd_cmd_o          <= 1'b0;
         user.cmd_valid_o  <= 1'b0;
         user.cmd_idx_o    <= '0;
         user.cmd_arg_o    <= '0;
         user.cmd_crc_ok_o <= 1'b0;
         bit_cnt           <= '0;
         gap               <= '0;
      end else begin
         clk_sync         <= {clk_sync[SYNC_STAGES-2:0], sd_clk_i};
         cmd_sync         <= {cmd_sync[SYNC_STAGES-2:0], sd_cmd_i};
         clk_prev         <= sclk;
         user.cmd_valid_o <= 1'b0;
         if (state == IDLE && rise && !scmd) bit_cnt <= 8'd1;
         if (state == RX && rise) begin
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == 8'd47) begin
               user.cmd_idx_o    <= rx_sr[44:39];
               user.cmd_arg_o    <= rx_sr[38:7];
               user.cmd_crc_ok_o <= (rx_sr[6:0] == crc) && scmd;
               user.cmd_valid_o  <= 1'b1;
               gap               <= '0;
            end
         end
         if ((state == WAIT_RESP || state == NCR_WAIT) && rise && gap != NCR_V)
            gap <= gap + 7'd1;
         if (tx_go) begin
            sd_cmd_o <= tx_sr[SR_W-1];
            bit_cnt  <= '0;
         end else if (tx_end) begin
            sd_cmd_o <= 1'b1;
         end else if (tx_step) begin
            sd_cmd_o <= tx_sr[SR_W-1];
            bit_cnt  <= bit_cnt + 8'd1;
         end
      end
   end

   // Data path: receive shift/CRC and transmit frame register
   always_ff @(posedge clk_i) begin
      if (state == IDLE && rise && !scmd) crc <= crc7_step(7'd0, 1'b0);
      if (state == RX && rise) begin
         rx_sr <= {rx_sr[43:0], scmd};
         if (bit_cnt < 8'd40) crc <= crc7_step(crc, scmd);
      end
      if (resp_take) begin
`ifdef NEOSD_CARD_LONG_RESP_EN
         if (user.resp_long_i) begin
            tx_sr   <= {2'b00, 6'h3F, user.resp_data_i, 1'b1};
            tx_last <= 8'd135;
         end else begin
            tx_sr   <= {resp_short, 88'd0};
            tx_last <= 8'd47;
         end
`else
         tx_sr   <= resp_short;
         tx_last <= 8'd47;
`endif
      end else if (tx_go || tx_step) begin
         tx_sr <= tx_sr << 1;
      end
   end

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Self-checking bench for neosd_card_cmd: table-driven command/response vectors plus corner sequences.
module tb_neosd_card_cmd;
   localparam int NCR = 2;

   logic clk = 1'b0, rstn = 1'b0, sd_clk = 1'b0, sd_cmd = 1'b1;
   logic sd_cmd_o, sd_cmd_oe;
   int   n_cmp = 0, n_bad = 0;
   logic tx_abort = 1'b0;
   logic [135:0] last_cap;
   int   last_n;

   neosd_card_cmd_if u();

   neosd_card_cmd #(.NCR(NCR), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rstn_i(rstn), .sd_clk_i(sd_clk), .sd_cmd_i(sd_cmd),
      .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .user(u)
   );

   always #5 clk = ~clk;
   initial begin
      #2;
      forever #40 sd_clk = ~sd_clk;
   end

   typedef struct { logic [5:0] idx; logic [31:0] arg; logic ok; } cmd_exp_t;
   typedef struct { int len; logic [135:0] frame; } rsp_exp_t;
   typedef struct {
      logic [47:0] frame; logic [5:0] idx; logic [31:0] arg; logic ok;
      int mode; logic [5:0] ridx; logic [31:0] rarg; logic [47:0] rframe;
   } vec_t;

   cmd_exp_t cmd_q[$];
   rsp_exp_t rsp_q[$];

   function automatic logic [6:0] crc7b(input logic [39:0] d);
      logic [46:0] r;
      r = {d, 7'd0};
      for (int i = 46; i >= 7; i--) if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] mkcmd(input logic [5:0] i, input logic [31:0] a);
      return {2'b01, i, a, crc7b({2'b01, i, a}), 1'b1};
   endfunction

   function automatic logic [47:0] mkresp(input logic [5:0] i, input logic [31:0] a);
      return {2'b00, i, a, crc7b({2'b00, i, a}), 1'b1};
   endfunction

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic sd_prev, oe_prev, rise;
      int gap, cap_n;
      logic [135:0] cap;
      cmd_exp_t e;
      rsp_exp_t r;
      sd_prev = 1'b0; oe_prev = 1'b0; gap = 0; cap_n = 0; cap = '0;
      forever begin
         @(negedge clk);
         rise    = sd_clk && !sd_prev;
         sd_prev = sd_clk;
         if (u.cmd_valid_o === 1'b1) begin
            gap = 0;
            if (cmd_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL cmd_unexpected: got pulse idx %0d, expected none", u.cmd_idx_o);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_idx", u.cmd_idx_o, e.idx);
               chk("cmd_arg", u.cmd_arg_o, e.arg);
               chk("cmd_crc_ok", u.cmd_crc_ok_o, e.ok);
            end
         end else if (rise) gap++;
         if (sd_cmd_oe && !oe_prev) begin
            chk("ncr_gap", gap, NCR);
            cap = '0; cap_n = 0;
         end
         if (sd_cmd_oe && rise) begin
            cap = {cap[134:0], sd_cmd_o};
            cap_n++;
         end
         if (!sd_cmd_oe && oe_prev) begin
            last_cap = cap; last_n = cap_n;
            if (!tx_abort) begin
               if (rsp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL resp_unexpected: got %0d bits, expected no response", cap_n);
               end else begin
                  r = rsp_q.pop_front();
                  chk("resp_len", cap_n, r.len);
                  chk("resp_frame", cap, r.frame);
               end
            end
         end
         oe_prev = sd_cmd_oe;
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      for (int i = 47; i >= 0; i--) begin
         @(negedge sd_clk); sd_cmd = f[i];
      end
      @(negedge sd_clk); sd_cmd = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 3000; i++) begin
         if (u.busy_o === 1'b0 && sd_cmd_oe === 1'b0) break;
         @(negedge clk);
      end
      chk({name, "_idle"}, u.busy_o, 1'b0);
      @(negedge clk);
   endtask

   task automatic drive_resp(input logic valid, input logic skip, input logic lng,
                             input logic [5:0] ri, input logic [31:0] ra);
      @(negedge clk);
      u.resp_idx_i = ri; u.resp_arg_i = ra; u.resp_long_i = lng;
      u.resp_valid_i = valid; u.resp_skip_i = skip;
      @(negedge clk);
      u.resp_valid_i = 1'b0; u.resp_skip_i = 1'b0;
   endtask

   // mode: 0 = skip, 1 = short response, 2 = skip and valid together (skip wins)
   task automatic apply_vec(input vec_t t, input int n);
      cmd_exp_t e;
      rsp_exp_t r;
      e.idx = t.idx; e.arg = t.arg; e.ok = t.ok;
      cmd_q.push_back(e);
      if (t.mode == 1) begin
         r.len = 48; r.frame = {88'd0, t.rframe};
         rsp_q.push_back(r);
      end
      send_frame(t.frame);
      drive_resp(t.mode != 0, t.mode != 1, 1'b0, t.ridx, t.rarg);
      wait_idle($sformatf("vec%0d", n));
      chk($sformatf("vec%0d_cmdq", n), cmd_q.size(), 0);
      chk($sformatf("vec%0d_rspq", n), rsp_q.size(), 0);
   endtask

   initial begin
      vec_t v[7];
      cmd_exp_t e;
      rsp_exp_t r;
      logic [126:0] d;
      time t0;

      v[0] = '{48'h400000000095, 6'd0, 32'h0, 1'b1, 0, 6'd0, 32'h0, 48'h0};
      v[1] = '{48'h510000000055, 6'd17, 32'h0, 1'b1, 1, 6'd0, 32'h0, 48'h000000000001};
      v[2] = '{48'h400000000097, 6'd0, 32'h0, 1'b0, 2, 6'd0, 32'h0, 48'h0};
      v[3] = '{mkcmd(6'd8, 32'h1AA), 6'd8, 32'h1AA, 1'b1, 1, 6'd8, 32'h1AA, mkresp(6'd8, 32'h1AA)};
      v[4] = '{mkcmd(6'd55, 32'h12340000), 6'd55, 32'h12340000, 1'b1, 1,
               6'd55, 32'h120, mkresp(6'd55, 32'h120)};
      v[5] = '{mkcmd(6'd17, 32'hDEADBEEF) & ~48'h1, 6'd17, 32'hDEADBEEF, 1'b0, 0, 6'd0, 32'h0, 48'h0};
      v[6] = '{mkcmd(6'd63, 32'hFFFFFFFF), 6'd63, 32'hFFFFFFFF, 1'b1, 1,
               6'd63, 32'hFFFFFFFF, mkresp(6'd63, 32'hFFFFFFFF)};

      u.resp_valid_i = 1'b0; u.resp_skip_i = 1'b0; u.resp_long_i = 1'b0;
      u.resp_idx_i = '0; u.resp_arg_i = '0; u.resp_data_i = '0;
      fork monitor(); join_none

      rstn = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_cmd_o", sd_cmd_o, 1'b0);
      chk("rst_cmd_oe", sd_cmd_oe, 1'b0);
      chk("rst_valid", u.cmd_valid_o, 1'b0);
      chk("rst_busy", u.busy_o, 1'b0);
      chk("rst_idx", u.cmd_idx_o, 6'd0);
      chk("rst_arg", u.cmd_arg_o, 32'd0);
      chk("rst_ok", u.cmd_crc_ok_o, 1'b0);
      rstn = 1'b1;

      @(posedge sd_clk); t0 = $time;
      @(posedge sd_clk);
      chk("sdclk_ratio_ge4", (($time - t0) / 10) >= 4, 1'b1);

      for (int i = 0; i < 7; i++) apply_vec(v[i], i);

      // Transmission bit 0: another card's response, must be dropped
      @(negedge sd_clk); sd_cmd = 1'b0;
      @(negedge sd_clk);
      chk("txbit0_rx_busy", u.busy_o, 1'b1);
      sd_cmd = 1'b0;
      @(negedge sd_clk); sd_cmd = 1'b1;
      chk("txbit0_idle", u.busy_o, 1'b0);
      repeat (2) @(negedge sd_clk);
      chk("txbit0_cmdq", cmd_q.size(), 0);

      // Long (R2) response request; the default build falls back to a short frame
      for (int i = 0; i < 127; i++) d[i] = (i % 2 == 0);
      e.idx = 6'd2; e.arg = 32'h0; e.ok = 1'b1;
      cmd_q.push_back(e);
`ifdef NEOSD_CARD_LONG_RESP_EN
      r.len = 136; r.frame = {2'b00, 6'h3F, d, 1'b1};
`else
      r.len = 48;  r.frame = {88'd0, mkresp(6'd2, 32'h0)};
`endif
      rsp_q.push_back(r);
      u.resp_data_i = d;
      send_frame(mkcmd(6'd2, 32'h0));
      drive_resp(1'b1, 1'b0, 1'b1, 6'd2, 32'h0);
      wait_idle("long");
      u.resp_long_i = 1'b0;
      chk("long_rspq", rsp_q.size(), 0);
      chk("long_end_bit", last_cap[0], 1'b1);
`ifdef NEOSD_CARD_LONG_RESP_EN
      chk("long_hdr", last_cap[135:128], 8'h3F);
`else
      chk("short_fallback_len", last_n, 48);
`endif

      // Reset while transmitting bit 20
      tx_abort = 1'b1;
      e.idx = 6'd17; e.arg = 32'h200; e.ok = 1'b1;
      cmd_q.push_back(e);
      send_frame(mkcmd(6'd17, 32'h200));
      drive_resp(1'b1, 1'b0, 1'b0, 6'd0, 32'h900);
      for (int i = 0; i < 2000; i++) begin
         if (sd_cmd_oe === 1'b1) break;
         @(negedge clk);
      end
      chk("abort_oe_up", sd_cmd_oe, 1'b1);
      repeat (20) @(negedge sd_clk);
      repeat (4) @(negedge clk);
      chk("abort_bit20_oe", sd_cmd_oe, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("abort_rst_oe", sd_cmd_oe, 1'b0);
      chk("abort_rst_busy", u.busy_o, 1'b0);
      chk("abort_rst_idx", u.cmd_idx_o, 6'd0);
      chk("abort_rst_arg", u.cmd_arg_o, 32'd0);
      repeat (3) @(negedge clk);
      tx_abort = 1'b0;
      apply_vec(v[0], 7);

      repeat (20) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
